norm_check_stream: RTL and testbench

- Streaming, multi-lane ML-DSA infinity-norm checker.
- Consumes NUM_LANES coefficients per beat from the memory read path for `num_poly_i` polynomials of NUM_COEFFS coefficients each.
- Compares every coefficient against the mode bound in a registered pipeline and accumulates a sticky invalid verdict.
- Sits between the sampler/memory controller and the signing/verify control FSM, which starts it and waits for done.

---
 rtl/norm_check_defines_pkg.sv | 39 +++
 rtl/norm_check_stream_if.sv | 12 +
 rtl/norm_check_lane.sv | 14 +
 rtl/norm_check_stream.sv | 162 ++++++++++++++++
 tb/tb_norm_check_stream.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/norm_check_defines_pkg.sv
// Shared definitions for the ML-DSA streaming infinity-norm checker:
// bound-select modes, controller states and the algorithm constants.
package norm_check_defines_pkg;

    localparam int unsigned MLDSA_Q      = 8380417;
    localparam int unsigned GAMMA1       = 2**19;
    localparam int unsigned MLDSA_GAMMA2 = (MLDSA_Q - 1) / 32;
    localparam int unsigned BETA         = 120;

    localparam int unsigned Z_BOUND   = GAMMA1 - BETA;
    localparam int unsigned R0_BOUND  = MLDSA_GAMMA2 - BETA;
    localparam int unsigned CT0_BOUND = MLDSA_GAMMA2;

    typedef enum logic [1:0] {
        CHK_Z_BOUND   = 2'd0,
        CHK_R0_BOUND  = 2'd1,
        CHK_CT0_BOUND = 2'd2,
        CHK_NONE      = 2'd3
    } chk_norm_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } norm_chk_st_e;

    // Lower bound for a mode; an unknown mode yields 0 so every coefficient
    // up to Q is flagged.
    function automatic int unsigned bound_of(chk_norm_mode_t mode);
        case (mode)
            CHK_Z_BOUND:   return Z_BOUND;
            CHK_R0_BOUND:  return R0_BOUND;
            CHK_CT0_BOUND: return CT0_BOUND;
            default:       return 0;
        endcase
    endfunction

endpackage

// File: rtl/norm_check_stream_if.sv
// Coefficient beat stream (valid/ready) from the memory read path.
// The source drives valid and data, the checker drives ready.
interface norm_check_stream_if #(
    parameter int WIDTH = 92
);
    logic             data_valid;
    logic             data_ready;
    logic [WIDTH-1:0] data;

    modport master (output data_valid, output data, input data_ready);
    modport slave  (input data_valid, input data, output data_ready);
endinterface

// File: rtl/norm_check_lane.sv
// Single-coefficient infinity-norm test: a coefficient is out of range when
// it lies in [bound, q_minus_bound], i.e. its centred magnitude reaches bound.
module norm_check_lane #(
    parameter int W = 23
) (
    input  logic [W-1:0] coeff,
    input  logic [W-1:0] bound,
    input  logic [W-1:0] q_minus_bound,
    output logic         bad
);

    assign bad = (coeff >= bound) && (coeff <= q_minus_bound);

endmodule

// File: rtl/norm_check_stream.sv
// Streaming multi-lane ML-DSA infinity-norm checker.
// Accepts num_poly polynomials as NUM_LANES-coefficient beats, checks each
// coefficient in a two-stage registered pipeline and reports a sticky
// invalid verdict with a done pulse three cycles after the last beat.
// Optional feature macro: NORM_CHECK_EARLY_ABORT_EN stops accepting beats
// as soon as the first out-of-range coefficient reaches the accumulator and
// exports the consumed beat count on beats_used_o.
module norm_check_stream
    import norm_check_defines_pkg::*;
#(
    parameter int REG_SIZE   = 24,
    parameter int NUM_LANES  = 4,
    parameter int NUM_COEFFS = 256,
    parameter int MAX_POLY   = 15
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                zeroize,
    input  logic                                start_i,
    input  chk_norm_mode_t                      mode_i,
    input  logic [$clog2(MAX_POLY+1)-1:0]       num_poly_i,
    norm_check_stream_if.slave                  bus,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                invalid_o
`ifdef NORM_CHECK_EARLY_ABORT_EN
    ,
    output logic [$clog2(MAX_POLY*NUM_COEFFS/NUM_LANES+1)-1:0] beats_used_o
`endif
);

    localparam int COEFF_W        = REG_SIZE - 1;
    localparam int NP_W           = $clog2(MAX_POLY + 1);
    localparam int BEATS_PER_POLY = NUM_COEFFS / NUM_LANES;
    localparam int MAX_BEATS      = MAX_POLY * BEATS_PER_POLY;
    localparam int CNT_W          = $clog2(MAX_BEATS + 1);

    norm_chk_st_e           state_q, state_d;
    chk_norm_mode_t         mode_q;
    logic [NP_W-1:0]        num_poly_q;
    logic [CNT_W-1:0]       beat_cnt;
    logic [CNT_W-1:0]       total_beats;
    logic                   drain_cnt;
    logic                   accept;
    logic                   last_beat;
    logic                   start_ok;
    logic                   acc_set;
    logic                   acc;
    logic                   invalid_q;
    logic [NUM_LANES-1:0]   lane_bad;
    logic [NUM_LANES-1:0]   s1_bad;
    logic                   s1_valid;
    logic [COEFF_W-1:0]     bound;
    logic [COEFF_W-1:0]     q_minus_bound;

    assign bound         = COEFF_W'(bound_of(mode_q));
    assign q_minus_bound = COEFF_W'(MLDSA_Q) - bound;

    assign total_beats   = CNT_W'(num_poly_q) * CNT_W'(BEATS_PER_POLY);
    assign last_beat     = (beat_cnt == total_beats - CNT_W'(1));
    assign bus.data_ready = (state_q == RUN);
    assign accept        = bus.data_valid && (state_q == RUN);
    assign start_ok      = start_i && (state_q == IDLE);
    assign acc_set       = s1_valid && (|s1_bad);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        norm_check_lane #(.W(COEFF_W)) u_lane (
            .coeff         (bus.data[l*COEFF_W +: COEFF_W]),
            .bound         (bound),
            .q_minus_bound (q_minus_bound),
            .bad           (lane_bad[l])
        );
    end

    // Next-state decode for the IDLE/RUN/DRAIN/DONE controller.
    always_comb begin
        // NOTE: every variable gets its default first so no path through the
        // case leaves it unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_poly_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && last_beat) begin
                    state_d = DRAIN;
                end
`ifdef NORM_CHECK_EARLY_ABORT_EN
                else if (acc_set) begin
                    state_d = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers: state, latched job parameters, beat and drain counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n || zeroize) begin
            state_q    <= IDLE;
            mode_q     <= CHK_Z_BOUND;
            num_poly_q <= '0;
            beat_cnt   <= '0;
            drain_cnt  <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_cnt <= (state_q == DRAIN) ? ~drain_cnt : 1'b0;
            if (start_ok) begin
                mode_q     <= mode_i;
                num_poly_q <= num_poly_i;
                beat_cnt   <= '0;
            end else if (accept && (beat_cnt != CNT_W'(MAX_BEATS))) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Check pipeline: stage 1 registers lane verdicts, stage 2 ORs them into
    // the sticky accumulator; the verdict is published on entry to DONE.
    always_ff @(posedge clk) begin
        // NOTE: the stage-1 datapath is cleared on reset too, so a zeroize
        // leaves nothing derived from secret coefficients behind.
        if (!reset_n || zeroize) begin
            s1_valid  <= 1'b0;
            s1_bad    <= '0;
            acc       <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_bad   <= lane_bad;
            if (start_ok) begin
                acc       <= 1'b0;
                invalid_q <= 1'b0;
            end else begin
                if (acc_set) begin
                    acc <= 1'b1;
                end
                if ((state_q == DRAIN) && (state_d == DONE)) begin
                    invalid_q <= acc;
                end
            end
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign invalid_o = invalid_q;
`ifdef NORM_CHECK_EARLY_ABORT_EN
    assign beats_used_o = beat_cnt;
`endif

endmodule

// File: tb/tb_norm_check_stream.sv
// Self-checking bench for norm_check_stream: directed boundary cases plus
// randomized runs, compared against a whole-array reference verdict.
module tb_norm_check_stream;
    import norm_check_defines_pkg::*;

    localparam int NUM_LANES  = 4;
    localparam int NUM_COEFFS = 256;
    localparam int COEFF_W    = 23;
    localparam int BUS_W      = NUM_LANES * COEFF_W;
    localparam int BEATS      = NUM_COEFFS / NUM_LANES;
    localparam longint Q      = 8380417;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           zeroize = 1'b0;
    logic           start_i = 1'b0;
    chk_norm_mode_t mode_i = CHK_Z_BOUND;
    logic [3:0]     num_poly_i = '0;
    logic           busy_o, done_o, invalid_o;
`ifdef NORM_CHECK_EARLY_ABORT_EN
    logic [9:0]     beats_used_o;
`endif

    norm_check_stream_if #(.WIDTH(BUS_W)) bus ();

    norm_check_stream dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .zeroize    (zeroize),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .num_poly_i (num_poly_i),
        .bus        (bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .invalid_o  (invalid_o)
`ifdef NORM_CHECK_EARLY_ABORT_EN
        ,
        .beats_used_o (beats_used_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned coeffs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference bound straight from the ML-DSA parameter definitions.
    function automatic longint ref_bound(chk_norm_mode_t m);
        case (m)
            CHK_Z_BOUND:   return longint'(2**19) - 120;
            CHK_R0_BOUND:  return (Q - 1) / 32 - 120;
            CHK_CT0_BOUND: return (Q - 1) / 32;
            default:       return 0;
        endcase
    endfunction

    function automatic bit coeff_bad(chk_norm_mode_t m, int unsigned c);
        longint b = ref_bound(m);
        return (longint'(c) >= b) && (longint'(c) <= Q - b);
    endfunction

    function automatic bit model_verdict(chk_norm_mode_t m, int np);
        for (int i = 0; i < np * NUM_COEFFS; i++) begin
            if (coeff_bad(m, coeffs[i])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int unsigned safe_coeff(chk_norm_mode_t m);
        int unsigned b = int'(ref_bound(m));
        if (b == 0) return $urandom_range(8388607, 8380418);
        if ($urandom_range(1) == 1) return $urandom_range(b - 1, 0);
        return $urandom_range(8388607, int'(Q) - b + 1);
    endfunction

    function automatic int unsigned bad_coeff(chk_norm_mode_t m);
        int unsigned b = int'(ref_bound(m));
        return $urandom_range(int'(Q) - b, b);
    endfunction

    task automatic fill_zero(input int np);
        coeffs.delete();
        for (int i = 0; i < np * NUM_COEFFS; i++) coeffs.push_back(0);
    endtask

    task automatic fill_safe(input chk_norm_mode_t m, input int np);
        coeffs.delete();
        for (int i = 0; i < np * NUM_COEFFS; i++) coeffs.push_back(safe_coeff(m));
    endtask

    function automatic logic [BUS_W-1:0] beat_data(int idx);
        logic [BUS_W-1:0] d = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            d[l*COEFF_W +: COEFF_W] = COEFF_W'(coeffs[idx*NUM_LANES + l]);
        end
        return d;
    endfunction

    // One start-to-done job. glitch_beat pulses start_i during RUN;
    // abort_beat fires reset/zeroize instead of completing (-1 disables).
    task automatic run_op(input string name, input chk_norm_mode_t mode, input int np,
                          input int pct, input int glitch_beat, input int abort_beat,
                          input bit use_zeroize, output bit verdict);
        int  total    = np * BEATS;
        int  budget   = total * 40 + 20;
        int  idx      = 0;
        int  cyc      = 0;
        int  last_acc = -1;
        int  done_cyc = -1;
        bit  exp_bad;
        logic [BUS_W-1:0] garbage = '0;
        for (int l = 0; l < NUM_LANES; l++) garbage[l*COEFF_W +: COEFF_W] = COEFF_W'(300000);
        exp_bad = model_verdict(mode, np);
        verdict = 1'b0;

        start_i    = 1'b1;
        mode_i     = mode;
        num_poly_i = 4'(np);
        @(negedge clk);
        start_i = 1'b0;
        check({name, ":invalid_cleared"}, invalid_o, 0);
        check({name, ":busy"}, busy_o, 1);

        while (cyc < budget) begin
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            start_i = 1'b0;
            bus.data_valid = 1'b0;
            if (idx < total) begin
                if ($urandom_range(99) < pct) begin
                    bus.data_valid = 1'b1;
                    bus.data       = beat_data(idx);
                end
            end else begin
                bus.data_valid = $urandom_range(1);
                bus.data       = garbage;
            end
            if (bus.data_valid && bus.data_ready) begin
                if (idx == abort_beat) begin
                    if (use_zeroize) zeroize = 1'b1;
                    else reset_n = 1'b0;
                    @(negedge clk);
                    zeroize = 1'b0;
                    reset_n = 1'b1;
                    bus.data_valid = 1'b0;
                    check({name, ":abort_busy"}, busy_o, 0);
                    check({name, ":abort_done"}, done_o, 0);
                    check({name, ":abort_invalid"}, invalid_o, 0);
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        if (done_o) check({name, ":abort_no_done"}, done_o, 0);
                    end
                    return;
                end
                if (idx == glitch_beat) begin
                    start_i = 1'b1;
                    mode_i  = CHK_NONE;
                    num_poly_i = 4'd1;
                end
                last_acc = cyc;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.data_valid = 1'b0;
        start_i = 1'b0;

        if (done_cyc < 0) begin
            check({name, ":done_timeout"}, 0, 1);
            return;
        end
        verdict = invalid_o;
        check({name, ":invalid"}, invalid_o, 32'(exp_bad));
`ifdef NORM_CHECK_EARLY_ABORT_EN
        check({name, ":beats_used"}, beats_used_o, idx);
`else
        check({name, ":beats"}, idx, total);
        if (np == 0) check({name, ":done_lat"}, done_cyc, 0);
        else check({name, ":done_lat"}, done_cyc - last_acc, 3);
`endif
        @(negedge clk);
        check({name, ":done_pulse"}, done_o, 0);
        check({name, ":idle"}, busy_o, 0);
        check({name, ":invalid_held"}, invalid_o, 32'(exp_bad));
        if (glitch_beat >= 0) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (done_o || busy_o) check({name, ":no_extra_done"}, {done_o, busy_o}, 0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit v1, v2, vr;
        chk_norm_mode_t rm;
        int rnp;
        bus.data_valid = 1'b0;
        bus.data       = '0;

        repeat (3) @(negedge clk);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_invalid", invalid_o, 0);
        check("reset_ready", bus.data_ready, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.data_ready, 0);

        fill_zero(1);
        coeffs[5]   = 524167;
        coeffs[200] = 7856250;
        run_op("z_edges", CHK_Z_BOUND, 1, 100, -1, -1, 0, vr);

        fill_zero(7);
        coeffs[1791] = 524168;
        run_op("z_np7", CHK_Z_BOUND, 7, 100, -1, -1, 0, vr);

        fill_zero(1);
        coeffs[77] = 261768;
        run_op("r0_at_bound", CHK_R0_BOUND, 1, 100, -1, -1, 0, vr);
        run_op("ct0_below", CHK_CT0_BOUND, 1, 100, -1, -1, 0, vr);
        coeffs[77] = 261888;
        run_op("ct0_at_bound", CHK_CT0_BOUND, 1, 100, -1, -1, 0, vr);
        coeffs[77] = 8118529;
        run_op("ct0_q_minus", CHK_CT0_BOUND, 1, 100, -1, -1, 0, vr);

        run_op("np0", CHK_Z_BOUND, 0, 100, -1, -1, 0, vr);

        fill_safe(CHK_Z_BOUND, 2);
        coeffs[$urandom_range(511)] = bad_coeff(CHK_Z_BOUND);
        run_op("gapfree_bad", CHK_Z_BOUND, 2, 100, -1, -1, 0, v1);
        run_op("gapped_bad", CHK_Z_BOUND, 2, 50, -1, -1, 0, v2);
        check("gap_verdict_bad", v2, 32'(v1));
        fill_safe(CHK_R0_BOUND, 2);
        run_op("gapfree_ok", CHK_R0_BOUND, 2, 100, -1, -1, 0, v1);
        run_op("gapped_ok", CHK_R0_BOUND, 2, 50, -1, -1, 0, v2);
        check("gap_verdict_ok", v2, 32'(v1));

        fill_safe(CHK_Z_BOUND, 2);
        run_op("start_glitch", CHK_Z_BOUND, 2, 100, 40, -1, 0, vr);

        fill_zero(1);
        coeffs[3] = 524168;
        run_op("rst_abort", CHK_Z_BOUND, 1, 100, -1, 30, 0, vr);
        run_op("after_rst", CHK_Z_BOUND, 1, 100, -1, -1, 0, vr);
        run_op("zero_abort", CHK_Z_BOUND, 1, 100, -1, 30, 1, vr);
        run_op("after_zero", CHK_Z_BOUND, 1, 100, -1, -1, 0, vr);

        for (int r = 0; r < 8; r++) begin
            rm  = chk_norm_mode_t'($urandom_range(3));
            rnp = $urandom_range(3, 1);
            fill_safe(rm, rnp);
            if ($urandom_range(1) == 1) coeffs[$urandom_range(rnp*NUM_COEFFS-1)] = bad_coeff(rm);
            run_op($sformatf("rand%0d", r), rm, rnp, $urandom_range(100, 30), -1, -1, 0, vr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
